core_control_fsm: RTL and testbench

//  Multi-cycle sequencer for the RV32I core; sits between opcode decode and the PC/regfile/ALU/memory datapath.

---
 rtl/core_control_fsm_pkg.sv | 31 +++
 rtl/core_control_fsm_if.sv | 11 +
 rtl/mem_timeout_counter.sv | 29 ++
 rtl/core_control_fsm.sv | 125 ++++++++++++
 tb/tb_core_control_fsm.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_control_fsm_pkg.sv
// rtl/core_control_fsm_pkg.sv - state, decode-class and trap-cause encodings for the core sequencer
package core_control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        INSTR_R = 3'd0,
        INSTR_I = 3'd1,
        INSTR_S = 3'd2,
        INSTR_B = 3'd3,
        INSTR_U = 3'd4,
        INSTR_J = 3'd5,
        INSTR_N = 3'd7
    } instr_type_t;

    typedef enum logic [1:0] {
        CAUSE_NONE         = 2'd0,
        CAUSE_ILLEGAL      = 2'd1,
        CAUSE_IMEM_TIMEOUT = 2'd2,
        CAUSE_DMEM_TIMEOUT = 2'd3
    } trap_cause_t;

endpackage

// File: rtl/core_control_fsm_if.sv
// rtl/core_control_fsm_if.sv - instruction/data memory request-ack handshakes
interface core_control_fsm_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_rd;
    logic dmem_wr;
    logic dmem_ack;

    modport master (output imem_req, dmem_rd, dmem_wr, input imem_ack, dmem_ack);
    modport slave  (input imem_req, dmem_rd, dmem_wr, output imem_ack, dmem_ack);
endinterface

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - wait-cycle counter shared by instruction fetch and data access
module mem_timeout_counter
    import core_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] count;

    // Saturates at the limit so a stalled owner never sees the count wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/core_control_fsm.sv
// rtl/core_control_fsm.sv - multi-cycle RV32I sequencer: fetch, decode, exec, mem, writeback, trap
module core_control_fsm
    import core_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic [2:0]                 instr_type,
    input  logic                       save_to_reg,
    input  logic                       rd_memory,
    input  logic                       wr_memory,
    input  logic                       is_branch,
    input  logic                       inc_pc,
    input  logic                       branch_taken,
    core_control_fsm_if.master         mem,
    output logic                       ir_load,
    output logic                       alu_en,
    output logic                       rf_we,
    output logic                       pc_we,
    output logic                       pc_sel,
    output logic                       instr_retired,
    output logic                       trap,
    output logic [1:0]                 trap_cause,
    output logic [2:0]                 state_o
);
    state_t      state, state_nxt;
    trap_cause_t cause_q, cause_nxt;
    logic        tmo_clr, tmo_en, tmo_expired;

    mem_timeout_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cause_nxt     = cause_q;
        tmo_clr       = 1'b1;
        tmo_en        = 1'b0;
        mem.imem_req  = 1'b0;
        mem.dmem_rd   = 1'b0;
        mem.dmem_wr   = 1'b0;
        ir_load       = 1'b0;
        alu_en        = 1'b0;
        rf_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 1'b0;
        instr_retired = 1'b0;

        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                mem.imem_req = 1'b1;
                tmo_clr      = 1'b0;
                tmo_en       = !mem.imem_ack;
                // An ack landing on the limit cycle still completes the fetch.
                if (mem.imem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (tmo_expired) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_IMEM_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (instr_type == INSTR_N) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_en    = 1'b1;
                state_nxt = (rd_memory || wr_memory) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                mem.dmem_rd = rd_memory;
                mem.dmem_wr = wr_memory;
                tmo_clr     = 1'b0;
                tmo_en      = !mem.dmem_ack;
                if (mem.dmem_ack) begin
                    state_nxt = ST_WB;
                end else if (tmo_expired) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_DMEM_TIMEOUT;
                end
            end
            ST_WB: begin
                rf_we         = save_to_reg || rd_memory;
                pc_we         = 1'b1;
                pc_sel        = is_branch && (inc_pc || branch_taken);
                instr_retired = 1'b1;
                state_nxt     = run ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: begin
                state_nxt = ST_TRAP;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign trap       = (state == ST_TRAP);
    assign trap_cause = cause_q;
    assign state_o    = state;
endmodule

// File: tb/tb_core_control_fsm.sv
// tb/tb_core_control_fsm.sv - scoreboard bench for the core sequencer
module tb_core_control_fsm;
    import core_control_fsm_pkg::*;

    localparam logic [8:0] F_IREQ = 9'h100;
    localparam logic [8:0] F_IRLD = 9'h080;
    localparam logic [8:0] F_ALU  = 9'h040;
    localparam logic [8:0] F_DRD  = 9'h020;
    localparam logic [8:0] F_DWR  = 9'h010;
    localparam logic [8:0] F_RFWE = 9'h008;
    localparam logic [8:0] F_PCWE = 9'h004;
    localparam logic [8:0] F_PSEL = 9'h002;
    localparam logic [8:0] F_RET  = 9'h001;
    localparam logic [8:0] F_NONE = 9'h000;

    typedef struct {
        logic [2:0] st;
        logic       run;
        logic       ia;
        logic       da;
        logic       bt;
        logic [8:0] fl;
        logic       tr;
        logic [1:0] cause;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, run, save_to_reg, rd_memory, wr_memory, is_branch, inc_pc, branch_taken;
    logic [2:0] instr_type;
    logic ir_load, alu_en, rf_we, pc_we, pc_sel, instr_retired, trap;
    logic [1:0] trap_cause;
    logic [2:0] state_o;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    core_control_fsm_if mif ();

    core_control_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .instr_type    (instr_type),
        .save_to_reg   (save_to_reg),
        .rd_memory     (rd_memory),
        .wr_memory     (wr_memory),
        .is_branch     (is_branch),
        .inc_pc        (inc_pc),
        .branch_taken  (branch_taken),
        .mem           (mif),
        .ir_load       (ir_load),
        .alu_en        (alu_en),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .instr_retired (instr_retired),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .state_o       (state_o)
    );

    function automatic logic [14:0] obs();
        return {state_o, mif.imem_req, ir_load, alu_en, mif.dmem_rd, mif.dmem_wr,
                rf_we, pc_we, pc_sel, instr_retired, trap, trap_cause};
    endfunction

    function automatic logic [14:0] want(input exp_t x);
        return {x.st, x.fl, x.tr, x.cause};
    endfunction

    task automatic push(input logic [2:0] st, input logic r, input logic ia, input logic da,
                        input logic bt, input logic [8:0] fl, input logic tr, input logic [1:0] cause);
        exp_t x;
        x.st = st; x.run = r; x.ia = ia; x.da = da; x.bt = bt; x.fl = fl; x.tr = tr; x.cause = cause;
        sb.push_back(x);
    endtask

    task automatic set_decode(input logic [2:0] t, input logic s, input logic rd, input logic wr,
                              input logic br, input logic ip);
        instr_type = t; save_to_reg = s; rd_memory = rd; wr_memory = wr; is_branch = br; inc_pc = ip;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs() !== 15'h0) begin
            errors++;
            $display("FAIL reset_initial: got %h want %h", obs(), 15'h0);
        end
        run = 1'b1;
        mif.imem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 15'h0) begin
            errors++;
            $display("FAIL reset_held: got %h want %h", obs(), 15'h0);
        end
        @(negedge clk);
        run = 1'b0; mif.imem_ack = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        int n = 0;
        set_decode(INSTR_I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(ST_IDLE,   1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_FETCH,  1, 1, 0, 0, F_IREQ | F_IRLD, 0, 0);
        push(ST_DECODE, 1, 1, 1, 0, F_NONE, 0, 0);
        push(ST_EXEC,   1, 0, 1, 0, F_ALU, 0, 0);
        push(ST_WB,     0, 0, 0, 0, F_RFWE | F_PCWE | F_RET, 0, 0);
        push(ST_IDLE,   0, 1, 1, 0, F_NONE, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            run = e.run; mif.imem_ack = e.ia; mif.dmem_ack = e.da; branch_taken = e.bt;
            #1;
            checks++;
            if (obs() !== want(e)) begin
                errors++;
                $display("FAIL addi step %0d: got %h want %h", n, obs(), want(e));
            end
            n++;
        end
    endtask

    task automatic test_load();
        int n = 0;
        set_decode(INSTR_I, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(ST_IDLE,   1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_FETCH,  1, 0, 0, 0, F_IREQ, 0, 0);
        push(ST_FETCH,  1, 1, 0, 0, F_IREQ | F_IRLD, 0, 0);
        push(ST_DECODE, 1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_EXEC,   1, 0, 1, 0, F_ALU, 0, 0);
        push(ST_MEM,    1, 0, 0, 0, F_DRD, 0, 0);
        push(ST_MEM,    1, 0, 0, 0, F_DRD, 0, 0);
        push(ST_MEM,    1, 0, 1, 0, F_DRD, 0, 0);
        push(ST_WB,     0, 0, 0, 0, F_RFWE | F_PCWE | F_RET, 0, 0);
        push(ST_IDLE,   0, 0, 0, 0, F_NONE, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            run = e.run; mif.imem_ack = e.ia; mif.dmem_ack = e.da; branch_taken = e.bt;
            #1;
            checks++;
            if (obs() !== want(e)) begin
                errors++;
                $display("FAIL load step %0d: got %h want %h", n, obs(), want(e));
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        set_decode(INSTR_B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(ST_IDLE,   1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_FETCH,  1, 1, 0, 0, F_IREQ | F_IRLD, 0, 0);
        push(ST_DECODE, 1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_EXEC,   1, 0, 0, 1, F_ALU, 0, 0);
        push(ST_WB,     1, 0, 0, 1, F_PCWE | F_PSEL | F_RET, 0, 0);
        push(ST_FETCH,  1, 1, 0, 1, F_IREQ | F_IRLD, 0, 0);
        push(ST_DECODE, 1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_EXEC,   1, 0, 0, 0, F_ALU, 0, 0);
        push(ST_WB,     0, 0, 0, 0, F_PCWE | F_RET, 0, 0);
        push(ST_IDLE,   0, 0, 0, 0, F_NONE, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            run = e.run; mif.imem_ack = e.ia; mif.dmem_ack = e.da; branch_taken = e.bt;
            #1;
            checks++;
            if (obs() !== want(e)) begin
                errors++;
                $display("FAIL branch step %0d: got %h want %h", n, obs(), want(e));
            end
            n++;
        end
    endtask

    task automatic test_jal();
        int n = 0;
        set_decode(INSTR_J, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        push(ST_IDLE,   1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_FETCH,  1, 1, 0, 0, F_IREQ | F_IRLD, 0, 0);
        push(ST_DECODE, 1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_EXEC,   1, 0, 0, 0, F_ALU, 0, 0);
        push(ST_WB,     0, 0, 0, 0, F_RFWE | F_PCWE | F_PSEL | F_RET, 0, 0);
        push(ST_IDLE,   0, 0, 0, 0, F_NONE, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            run = e.run; mif.imem_ack = e.ia; mif.dmem_ack = e.da; branch_taken = e.bt;
            #1;
            checks++;
            if (obs() !== want(e)) begin
                errors++;
                $display("FAIL jal step %0d: got %h want %h", n, obs(), want(e));
            end
            n++;
        end
    endtask

    task automatic test_illegal();
        int n = 0;
        set_decode(INSTR_N, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(ST_IDLE,   1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_FETCH,  1, 1, 0, 0, F_IREQ | F_IRLD, 0, 0);
        push(ST_DECODE, 1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_TRAP,   1, 1, 1, 0, F_NONE, 1, 2'd1);
        push(ST_TRAP,   0, 1, 0, 0, F_NONE, 1, 2'd1);
        push(ST_TRAP,   1, 0, 1, 0, F_NONE, 1, 2'd1);
        push(ST_TRAP,   1, 1, 0, 0, F_NONE, 1, 2'd1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            run = e.run; mif.imem_ack = e.ia; mif.dmem_ack = e.da; branch_taken = e.bt;
            #1;
            checks++;
            if (obs() !== want(e)) begin
                errors++;
                $display("FAIL illegal step %0d: got %h want %h", n, obs(), want(e));
            end
            n++;
        end
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;
        #1;
        checks++;
        if (obs() !== 15'h0) begin
            errors++;
            $display("FAIL illegal_reset: got %h want %h", obs(), 15'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        int n = 0;
        set_decode(INSTR_I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(ST_IDLE, 1, 0, 0, 0, F_NONE, 0, 0);
        for (int i = 0; i < 16; i++) push(ST_FETCH, 1, 0, 0, 0, F_IREQ, 0, 0);
        push(ST_TRAP, 1, 1, 0, 0, F_NONE, 1, 2'd2);
        push(ST_TRAP, 1, 0, 0, 0, F_NONE, 1, 2'd2);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            run = e.run; mif.imem_ack = e.ia; mif.dmem_ack = e.da; branch_taken = e.bt;
            #1;
            checks++;
            if (obs() !== want(e)) begin
                errors++;
                $display("FAIL imem_timeout step %0d: got %h want %h", n, obs(), want(e));
            end
            n++;
        end
        pulse_reset();

        n = 0;
        set_decode(INSTR_S, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(ST_IDLE,   1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_FETCH,  1, 1, 0, 0, F_IREQ | F_IRLD, 0, 0);
        push(ST_DECODE, 1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_EXEC,   1, 0, 0, 0, F_ALU, 0, 0);
        for (int i = 0; i < 16; i++) push(ST_MEM, 1, 0, 0, 0, F_DWR, 0, 0);
        push(ST_TRAP,   1, 0, 1, 0, F_NONE, 1, 2'd3);
        push(ST_TRAP,   1, 0, 0, 0, F_NONE, 1, 2'd3);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            run = e.run; mif.imem_ack = e.ia; mif.dmem_ack = e.da; branch_taken = e.bt;
            #1;
            checks++;
            if (obs() !== want(e)) begin
                errors++;
                $display("FAIL dmem_timeout step %0d: got %h want %h", n, obs(), want(e));
            end
            n++;
        end
        pulse_reset();

        n = 0;
        push(ST_IDLE,   1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_FETCH,  1, 1, 0, 0, F_IREQ | F_IRLD, 0, 0);
        push(ST_DECODE, 1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_EXEC,   1, 0, 0, 0, F_ALU, 0, 0);
        for (int i = 0; i < 15; i++) push(ST_MEM, 1, 0, 0, 0, F_DWR, 0, 0);
        push(ST_MEM,    1, 0, 1, 0, F_DWR, 0, 0);
        push(ST_WB,     0, 0, 0, 0, F_PCWE | F_RET, 0, 0);
        push(ST_IDLE,   0, 0, 0, 0, F_NONE, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            run = e.run; mif.imem_ack = e.ia; mif.dmem_ack = e.da; branch_taken = e.bt;
            #1;
            checks++;
            if (obs() !== want(e)) begin
                errors++;
                $display("FAIL ack_at_limit step %0d: got %h want %h", n, obs(), want(e));
            end
            n++;
        end
    endtask

    task automatic test_run_stop();
        int n = 0;
        set_decode(INSTR_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(ST_IDLE,   1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_FETCH,  1, 1, 0, 0, F_IREQ | F_IRLD, 0, 0);
        push(ST_DECODE, 1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_EXEC,   0, 0, 0, 0, F_ALU, 0, 0);
        push(ST_WB,     0, 0, 0, 0, F_RFWE | F_PCWE | F_RET, 0, 0);
        push(ST_IDLE,   0, 1, 0, 0, F_NONE, 0, 0);
        push(ST_IDLE,   0, 1, 1, 0, F_NONE, 0, 0);
        push(ST_IDLE,   0, 0, 0, 0, F_NONE, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            run = e.run; mif.imem_ack = e.ia; mif.dmem_ack = e.da; branch_taken = e.bt;
            #1;
            checks++;
            if (obs() !== want(e)) begin
                errors++;
                $display("FAIL run_stop step %0d: got %h want %h", n, obs(), want(e));
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_mem();
        int n = 0;
        set_decode(INSTR_S, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(ST_IDLE,   1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_FETCH,  1, 1, 0, 0, F_IREQ | F_IRLD, 0, 0);
        push(ST_DECODE, 1, 0, 0, 0, F_NONE, 0, 0);
        push(ST_EXEC,   1, 0, 0, 0, F_ALU, 0, 0);
        push(ST_MEM,    1, 0, 0, 0, F_DWR, 0, 0);
        push(ST_MEM,    1, 0, 0, 0, F_DWR, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk);
            run = e.run; mif.imem_ack = e.ia; mif.dmem_ack = e.da; branch_taken = e.bt;
            #1;
            checks++;
            if (obs() !== want(e)) begin
                errors++;
                $display("FAIL mid_mem step %0d: got %h want %h", n, obs(), want(e));
            end
            n++;
        end
        @(posedge clk);
        #3;
        checks++;
        if ({state_o, mif.dmem_wr} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL mid_mem_before_reset: got %h want %h", {state_o, mif.dmem_wr}, {3'd4, 1'b1});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 15'h0) begin
            errors++;
            $display("FAIL mid_mem_async_reset: got %h want %h", obs(), 15'h0);
        end
        @(negedge clk);
        rst_n = 1'b1; run = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; branch_taken = 1'b0;
        mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;
        set_decode(INSTR_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_addi();
        test_load();
        test_back_to_back();
        test_jal();
        test_illegal();
        test_timeout();
        test_run_stop();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
